// File: rtl/bus_mem_responder.sv
// bus_mem_responder
//   Target end of the hart's external bus: a word-organised on-chip RAM that
//   answers requests falling inside [BASE_ADDR, BASE_ADDR + 4*MEM_WORDS).
//   Requests outside the window are ignored, so several responders can share
//   the bus.
//   Supports programmable wait states and byte/half/word lanes.
//   Loads are sign- or zero-extended.
//   o_ack, o_rd_data and o_err are zero whenever this responder is not
//   acknowledging, so they can be OR-combined with other responders.
//
// Optional feature macro: BUS_RESP_ERR_EN
//   When defined, o_err exists. A misaligned or invalid-size access inside
//   the window still acks after the normal latency, with o_err=1.
//   Such an access writes nothing and returns o_rd_data=0.
//   When undefined, misaligned low address bits are ignored and invalid
//   sizes behave as word accesses.
//
// Ports
//   i_clk      in   1   clock, rising edge
//   i_rst      in   1   asynchronous reset, active low
//   i_bus_en   in   1   request valid, held with all fields until o_ack
//   i_wr_rd    in   1   1 = write, 0 = read
//   i_addr     in   32  byte address
//   i_wr_data  in   32  right-aligned write data
//   i_size     in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//   o_ack      out  1   one-cycle completion pulse
//   o_rd_data  out  32  read data while o_ack on a read, else 0
//   o_err      out  1   error flag qualified by o_ack (BUS_RESP_ERR_EN only)

module bus_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_bus_en,
  input  logic        i_wr_rd,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  input  logic [2:0]  i_size,
  output logic        o_ack,
  output logic [31:0] o_rd_data
`ifdef BUS_RESP_ERR_EN
  ,
  output logic        o_err
`endif
);

  localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] WIN_END   = {1'b0, BASE_ADDR} + 33'(MEM_WORDS) * 33'd4;
  localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t state, state_nx;

  logic [31:0] mem [MEM_WORDS];

  logic [3:0]       cnt;
  logic             req_wr;
  logic [IDX_W-1:0] req_idx;
  logic [1:0]       req_off;
  logic [31:0]      req_wdata;
  logic [2:0]       req_size;

  logic [31:0]      rel_addr;
  logic             hit, accept, enter_ack, bad, commit;
  logic             cur_wr;
  logic [IDX_W-1:0] cur_idx;
  logic [1:0]       cur_off;
  logic [31:0]      cur_wdata;
  logic [2:0]       cur_size;
  logic [3:0]       be;
  logic [31:0]      wr_lanes, rd_word, rd_ext, rd_val;
  logic [7:0]       bsel;
  logic [15:0]      hsel;

  assign rel_addr = i_addr - BASE_ADDR;
  // 33-bit compare so a window touching the top of the address space cannot wrap
  assign hit      = ({1'b0, i_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, i_addr} < WIN_END);
  assign accept   = (state == ST_IDLE) && i_bus_en && hit;

  // With zero wait states the access completes on the accepting edge, before
  // the latch is loaded, so the live request is used while still in IDLE.
  always_comb begin
    if (state == ST_IDLE) begin
      cur_wr    = i_wr_rd;
      cur_idx   = IDX_W'(rel_addr >> 2);
      cur_off   = i_addr[1:0];
      cur_wdata = i_wr_data;
      cur_size  = i_size;
    end else begin
      cur_wr    = req_wr;
      cur_idx   = req_idx;
      cur_off   = req_off;
      cur_wdata = req_wdata;
      cur_size  = req_size;
    end
  end

  always_comb begin
    state_nx = state;
    if (!i_rst) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) state_nx = (WAIT_STATES > 0) ? ST_WAIT : ST_ACK;
        ST_WAIT: if (cnt == '0) state_nx = ST_ACK;
        ST_ACK:  state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // ACK always falls back to IDLE, so this is true only on the entering edge
  assign enter_ack = (state_nx == ST_ACK);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt       <= '0;
      req_wr    <= 1'b0;
      req_idx   <= '0;
      req_off   <= '0;
      req_wdata <= '0;
      req_size  <= '0;
    end else if (accept) begin
      cnt       <= WAIT_INIT;
      req_wr    <= i_wr_rd;
      req_idx   <= IDX_W'(rel_addr >> 2);
      req_off   <= i_addr[1:0];
      req_wdata <= i_wr_data;
      req_size  <= i_size;
    end else if (state == ST_WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Lane steering. Size[1:0] selects the width; size[2] selects zero extension.
  always_comb begin
    be       = 4'b1111;
    wr_lanes = cur_wdata;
    rd_word  = mem[cur_idx];
    rd_ext   = rd_word;
    bsel     = rd_word[{cur_off, 3'b000} +: 8];
    hsel     = cur_off[1] ? rd_word[31:16] : rd_word[15:0];
    case (cur_size[1:0])
      2'b00: begin
        be       = 4'b0001 << cur_off;
        wr_lanes = {4{cur_wdata[7:0]}};
        rd_ext   = cur_size[2] ? {24'h0, bsel} : {{24{bsel[7]}}, bsel};
      end
      2'b01: begin
        be       = cur_off[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{cur_wdata[15:0]}};
        rd_ext   = cur_size[2] ? {16'h0, hsel} : {{16{hsel[15]}}, hsel};
      end
      default: begin
        be       = 4'b1111;
        wr_lanes = cur_wdata;
        rd_ext   = rd_word;
      end
    endcase
  end

`ifdef BUS_RESP_ERR_EN
  assign bad = (cur_size == 3'b011) || (cur_size[2:1] == 2'b11) ||
               (cur_size[1:0] == 2'b01 && cur_off[0]) ||
               (cur_size == 3'b010 && cur_off != 2'b00);
`else
  assign bad = 1'b0;
`endif

  assign commit = enter_ack && cur_wr && !bad;
  assign rd_val = (enter_ack && !cur_wr && !bad) ? rd_ext : '0;

  always_ff @(posedge i_clk) begin
    if (commit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[cur_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_ack     <= 1'b0;
      o_rd_data <= '0;
`ifdef BUS_RESP_ERR_EN
      o_err     <= 1'b0;
`endif
    end else begin
      o_ack     <= enter_ack;
      o_rd_data <= rd_val;
`ifdef BUS_RESP_ERR_EN
      o_err     <= enter_ack && bad;
`endif
    end
  end

endmodule
